// File: rtl/video_pkg.sv
// Shared video constants: sync polarity encodings and default
// counter widths common to the scandoubler and output stage.
package video_pkg;

    localparam logic POL_ACTIVE_LOW  = 1'b0;
    localparam logic POL_ACTIVE_HIGH = 1'b1;

    localparam int HSCNT_W_DEF = 12;
    localparam int VSCNT_W_DEF = 11;

endpackage

// File: rtl/video_sync_norm_sync_pol_detect.sv
// Measures high and low run lengths of one sync signal and
// reports which level is the short (active) one.
module sync_pol_detect
    import video_pkg::*;
#(
    parameter int CNT_W = HSCNT_W_DEF
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic sig,
    input  logic count_en,
    output logic pol
);

    logic             sig_d;
    logic             upd;
    logic             lo_ok;
    logic             hi_ok;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lo_len;
    logic [CNT_W-1:0] hi_len;
    logic             sig_edge;
    logic             sig_rise;

    always_comb begin
        sig_edge = sig ^ sig_d;
        sig_rise = sig & ~sig_d;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sig_d  <= 1'b0;
            upd    <= 1'b0;
            lo_ok  <= 1'b0;
            hi_ok  <= 1'b0;
            cnt    <= '0;
            lo_len <= '0;
            hi_len <= '0;
            pol    <= POL_ACTIVE_LOW;
        end else begin
            sig_d <= sig;
            upd   <= sig_edge;
            // An edge restarts the run and swallows a coincident count strobe
            if (sig_edge) begin
                cnt <= '0;
                if (sig_rise) begin
                    lo_len <= cnt;
                    lo_ok  <= 1'b1;
                end else begin
                    hi_len <= cnt;
                    hi_ok  <= 1'b1;
                end
            end else if (count_en && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            if (upd && lo_ok && hi_ok) begin
                if (hi_len < lo_len)
                    pol <= POL_ACTIVE_HIGH;
                else if (hi_len > lo_len)
                    pol <= POL_ACTIVE_LOW;
            end
        end
    end

endmodule

// File: rtl/video_sync_norm.sv
// Scandoubler output conditioner: normalises syncs to active-low,
// optional composite sync, and blanks RGB during sync.
module video_sync_norm
    import video_pkg::*;
#(
    parameter int HSCNT_WIDTH = HSCNT_W_DEF,
    parameter int VSCNT_WIDTH = VSCNT_W_DEF
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       pixel_ena,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic [5:0] r_in,
    input  logic [5:0] g_in,
    input  logic [5:0] b_in,
    input  logic       csync_en,
    output logic       hs_out,
    output logic       vs_out,
    output logic [5:0] r_out,
    output logic [5:0] g_out,
    output logic [5:0] b_out,
    output logic       hs_pol,
    output logic       vs_pol
);

    logic hs_d;
    logic hs_rise;
    logic hs_n;
    logic vs_n;

    always_ff @(posedge clk_sys) begin
        if (reset)
            hs_d <= 1'b0;
        else
            hs_d <= hs_in;
    end

    always_comb begin
        hs_rise = hs_in & ~hs_d;
        hs_n    = hs_in ^ hs_pol;
        vs_n    = vs_in ^ vs_pol;
    end

    sync_pol_detect #(
        .CNT_W(HSCNT_WIDTH)
    ) u_hs_det (
        .clk_sys (clk_sys),
        .reset   (reset),
        .sig     (hs_in),
        .count_en(1'b1),
        .pol     (hs_pol)
    );

    // Vsync run lengths are measured in lines
    sync_pol_detect #(
        .CNT_W(VSCNT_WIDTH)
    ) u_vs_det (
        .clk_sys (clk_sys),
        .reset   (reset),
        .sig     (vs_in),
        .count_en(hs_rise),
        .pol     (vs_pol)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hs_out <= 1'b1;
            vs_out <= 1'b1;
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
        end else if (pixel_ena) begin
            hs_out <= csync_en ? (hs_n & vs_n) : hs_n;
            vs_out <= csync_en ? 1'b1 : vs_n;
            if (hs_n && vs_n) begin
                r_out <= r_in;
                g_out <= g_in;
                b_out <= b_in;
            end else begin
                r_out <= '0;
                g_out <= '0;
                b_out <= '0;
            end
        end
    end

endmodule

// File: doc/video_sync_norm.md
Name: video_sync_norm

Overview:
- Output conditioner directly downstream of the scandoubler.
- Consumes the scandoubler's hs_out, vs_out, r_out, g_out, b_out and pixel_ena.
- Measures the polarity of each sync signal and normalises both syncs to active-low.
- Optionally merges the syncs into composite sync and forces RGB to black while sync is active, then drives the VGA/DAC pins.

Parameters:
- HSCNT_WIDTH, 12: width of the clk_sys-cycle counters that measure hsync high and low time. These counters saturate.
- VSCNT_WIDTH, 11: width of the line counters that measure vsync high and low time. These counters saturate.

Ports:
- clk_sys  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- pixel_ena  in  1  pixel clock enable from the scandoubler.
- hs_in  in  1  horizontal sync, either polarity.
- vs_in  in  1  vertical sync, either polarity.
- r_in, g_in, b_in  in  6 each  pixel colour.
- csync_en  in  1  1 = composite sync on hs_out and vs_out held at 1.
- hs_out  out  1  active-low hsync, or csync when csync_en=1.
- vs_out  out  1  active-low vsync.
- r_out, g_out, b_out  out  6 each  colour, blanked during sync.
- hs_pol  out  1  detected hsync polarity; 1 = active-high input.
- vs_pol  out  1  detected vsync polarity; 1 = active-high input.

Behaviour:
- Clock and reset: one clock, clk_sys. Reset is synchronous and active-high, named reset.
- Reset values:
  - hs_out=1, vs_out=1; r_out, g_out, b_out = 0.
  - hs_pol=0, vs_pol=0.
  - All measurement counters = 0; length registers = 0; valid flags = 0.
  - Input delay registers = 0.
  - Reset mid-frame discards partial measurements. Polarity falls back to 0 until fresh measurements complete.
- Edge detection: hs_in and vs_in are registered every clk_sys cycle (hsD, vsD). An edge is hsD != hs_in.
- Hsync measurement:
  - hcnt increments every clk_sys cycle and saturates at all-ones.
  - On a rising edge: hs_low_len <= hcnt, hcnt <= 0, hs_low_ok <= 1.
  - On a falling edge: hs_high_len <= hcnt, hcnt <= 0, hs_high_ok <= 1.
- Hsync polarity update:
  - Evaluated in the cycle after any hs edge, only when hs_low_ok && hs_high_ok.
  - hs_pol <= (hs_high_len < hs_low_len). If the lengths are equal, hs_pol holds.
  - If hsync stops, hcnt saturates and hs_pol holds its last value.
- Vsync measurement:
  - vcnt counts hs_in rising edges and saturates at all-ones.
  - Rising vs edge: vs_low_len <= vcnt, vcnt <= 0, vs_low_ok <= 1.
  - Falling vs edge: vs_high_len <= vcnt, vcnt <= 0, vs_high_ok <= 1.
  - A vs edge coincident with an hs rising edge takes priority: vcnt becomes 0 and that hs edge is not counted.
- Vsync polarity update: vs_pol is updated by the same rule as hs_pol, using the vs lengths and the vs valid flags.
- Normalisation (combinational from the registered inputs):
  - hs_n = hs_in XOR hs_pol.
  - vs_n = vs_in XOR vs_pol.
- Output register: updated only when pixel_ena=1; otherwise it holds.
  - hs_out <= csync_en ? (hs_n & vs_n) : hs_n.
  - vs_out <= csync_en ? 1 : vs_n.
  - RGB is zeroed when hs_n==0 or vs_n==0; otherwise RGB passes through.
  - Latency: one pixel_ena strobe from input to output. Sync and colour stay aligned.
- Polarity flips: when hs_pol or vs_pol changes, the change takes effect at the next pixel_ena. No glitch occurs between strobes.

Decomposition:
- Shared package video_pkg holds:
  - the POL_ACTIVE_LOW / POL_ACTIVE_HIGH constants;
  - default counter widths shared with the scandoubler (HSCNT_WIDTH=12).
- One sub-module, sync_pol_detect, parameterised by count width, with inputs clk_sys, reset, sig, count_en and output pol.
  - Instantiated twice.
  - hsync instance: count_en = 1.
  - vsync instance: count_en = hs rising-edge pulse.

Test Plan:
1. Positive sync: hs_in period 1000 cycles with a 96-cycle high pulse, 10 lines. Expect hs_pol=1 after the second line. hs_out low for 96 cycles per line, aligned to pixel_ena. RGB 0x3F during the pulse gives r_out=0.
2. Negative sync: hs_in low for 96 of 1000 cycles and vs_in low for 2 of 525 lines, run 2 frames. Expect hs_pol=0 and vs_pol=0. Outputs equal the inputs delayed one pixel_ena.
3. Composite: csync_en=1 with positive hs and vs. Expect vs_out=1 constant. hs_out=0 whenever either normalised sync is low; hs_out=1 otherwise.
4. Polarity change mid-stream: switch hs_in from active-low to active-high. hs_pol flips within 2 lines. No hs_out transition occurs between pixel_ena strobes.
5. Stalled / equal sync: hold hs_in=1 for 5000 cycles; hcnt saturates at 4095 and hs_pol is unchanged. With a 50% duty sync (500/500), hs_pol holds.
6. Reset mid-frame: assert reset for 1 cycle during a vsync pulse. Next cycle hs_out=1, vs_out=1, RGB=0, pols=0. vs_pol is re-detected only after both vs edges are seen again.
